// File: rtl/reset_ctrl_pkg.sv
// Shared types and default constants for the reset/clock-enable sequencer.
package reset_ctrl_pkg;

  localparam int unsigned LOCK_CYCLES_DEF = 1024;
  localparam int unsigned DIV_DEF         = 4;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    COUNT     = 2'd1,
    RUN       = 2'd2
  } state_t;

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchroniser for a single asynchronous input; resets to 0.
module sync_bit (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_ctrl.sv
// Holds the system in reset until PLL lock is stable, then strobes cpu_en.
module reset_ctrl #(
  parameter int unsigned LOCK_CYCLES = reset_ctrl_pkg::LOCK_CYCLES_DEF,
  parameter int unsigned DIV         = reset_ctrl_pkg::DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_locked,
  output logic sys_reset,
  output logic cpu_en,
  output logic lock_lost
);

  import reset_ctrl_pkg::*;

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             run_nxt;
  logic             lock_s;

  sync_bit u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Look-ahead of the RUN state and divider so outputs register alongside state
  always_comb begin
    run_nxt = 1'b0;
    div_nxt = '0;
    if (lock_s && ((state == RUN) || ((state == COUNT) && (cnt == CNT_LAST)))) begin
      run_nxt = 1'b1;
    end
    if (run_nxt && (state == RUN)) begin
      div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Lock-qualification FSM, divider and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      div_cnt   <= '0;
      sys_reset <= 1'b1;
      cpu_en    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      sys_reset <= ~run_nxt;
      cpu_en    <= run_nxt && (div_nxt == DIV_LAST);
      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= COUNT;
            cnt   <= '0;
          end
        end
        COUNT: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            lock_lost <= 1'b1;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: three parameterisations driven from vector tables.
module tb_reset_ctrl;

  typedef struct {
    logic       lk;
    logic       rs;
    logic [2:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] exp;
    string      name;
  } sb_t;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] lk_v;
  logic       sr0, en0, ll0;
  logic       sr1, en1, ll1;
  logic       sr2, en2, ll2;

  vec_t tbl[$];
  sb_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reset_ctrl #(.LOCK_CYCLES(4), .DIV(4)) u_a (
    .clk(clk), .reset(rst_v[0]), .pll_locked(lk_v[0]),
    .sys_reset(sr0), .cpu_en(en0), .lock_lost(ll0)
  );

  reset_ctrl #(.LOCK_CYCLES(1), .DIV(1)) u_b (
    .clk(clk), .reset(rst_v[1]), .pll_locked(lk_v[1]),
    .sys_reset(sr1), .cpu_en(en1), .lock_lost(ll1)
  );

  reset_ctrl #(.LOCK_CYCLES(1024), .DIV(3)) u_c (
    .clk(clk), .reset(rst_v[2]), .pll_locked(lk_v[2]),
    .sys_reset(sr2), .cpu_en(en2), .lock_lost(ll2)
  );

  function automatic logic [2:0] obs(input int sel);
    case (sel)
      0:       return {sr0, en0, ll0};
      1:       return {sr1, en1, ll1};
      default: return {sr2, en2, ll2};
    endcase
  endfunction

  // Pop the oldest expectation and compare it with the selected instance
  task automatic check(input int sel);
    sb_t        e;
    logic [2:0] got;
    got = obs(sel);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty dut=%0d got=%b", sel, got);
      return;
    end
    e = exp_q.pop_front();
    if (got !== e.exp) begin
      bad++;
      $display("FAIL %s dut=%0d got {sys_reset,cpu_en,lock_lost}=%b want %b",
               e.name, sel, got, e.exp);
    end
  endtask

  function automatic void add(input logic lk, input logic rs,
                              input logic sr, input logic en, input logic ll);
    vec_t v;
    v.lk  = lk;
    v.rs  = rs;
    v.exp = {sr, en, ll};
    tbl.push_back(v);
  endfunction

  // Drive one table row per clock, record expectation, check after the edge
  task automatic apply_tbl(input int sel, input string tag);
    sb_t s;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_v[sel] = tbl[i].rs;
      lk_v[sel]  = tbl[i].lk;
      s.exp  = tbl[i].exp;
      s.name = $sformatf("%s[%0d]", tag, i);
      exp_q.push_back(s);
      @(posedge clk);
      #1;
      check(sel);
    end
    tbl.delete();
  endtask

  initial begin
    sb_t s;
    rst_v = 3'b111;
    lk_v  = 3'b000;
    repeat (2) @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      s.exp  = 3'b100;
      s.name = "reset_state";
      exp_q.push_back(s);
      check(d);
    end

    // LOCK_CYCLES=4 DIV=4: release, strobes, loss at edge 21, re-lock at edge 25
    for (int k = 1; k <= 36; k++) begin
      if (k <= 22)
        add((k <= 20) || (k >= 25), 1'b0, k < 7, (k >= 7) && ((k - 6) % 4 == 0), 1'b0);
      else if (k <= 30)
        add(k >= 25, 1'b0, 1'b1, 1'b0, 1'b1);
      else
        add(1'b1, 1'b0, 1'b0, (k - 30) % 4 == 0, 1'b1);
    end
    apply_tbl(0, "release_loss");

    // Asynchronous reset between edges while running with lock_lost set
    @(posedge clk);
    #3;
    rst_v[0] = 1'b1;
    s.exp  = 3'b100;
    s.name = "reset_mid_run";
    exp_q.push_back(s);
    #1;
    check(0);

    // Reset released with lock already high
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) add(1'b1, 1'b0, k < 7, 1'b0, 1'b0);
    apply_tbl(0, "rerelease");

    // Lock drops one edge short of release; full count restarts from edge 7
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++)
      add(!((k == 5) || (k == 6)), 1'b0, k < 13, (k >= 13) && ((k - 12) % 4 == 0), 1'b0);
    apply_tbl(0, "glitch");

    // LOCK_CYCLES=1 DIV=1: reset wins over lock, release after edge 4, loss at 11
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      if (k < 4)       add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else if (k < 13) add(k <= 10, 1'b0, 1'b0, 1'b1, 1'b0);
      else             add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    apply_tbl(1, "div1");

    // LOCK_CYCLES=1024 DIV=3: release after edge 1027, then 1000 strobes
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 1027 + 3000; k++) begin
      if (k < 1027) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else          add(1'b1, 1'b0, 1'b0, (k - 1026) % 3 == 0, 1'b0);
    end
    apply_tbl(2, "long");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_ctrl.md
# reset_ctrl

Reset and clock-enable sequencer sitting directly downstream of the iCE40 PLL clock block. Runs on the PLL's global output clock, synchronises the PLL lock flag, and holds the system in reset until lock has been continuously stable for a programmable number of cycles. Once running, it produces a periodic clock-enable strobe for the Hack CPU. If lock is lost, it drops the system back into reset.

## Interface

Parameters:
- `LOCK_CYCLES`, default 1024: consecutive synchronised-lock cycles required before releasing reset; legal range ≥ 1.
- `DIV`, default 4: `cpu_en` period in `clk` cycles; legal range ≥ 1.

Ports:
- `clk`  in  1: system clock (PLL global output). One clock domain only.
- `reset`  in  1: asynchronous, active-high reset (power-on/button).
- `pll_locked`  in  1: PLL LOCK flag, asynchronous to `clk`.
- `sys_reset`  out  1: registered, active-high system reset. Asserts asynchronously with `reset`; deasserts synchronously to `clk`.
- `cpu_en`  out  1: registered, single-cycle CPU clock-enable strobe.
- `lock_lost`  out  1: sticky flag. Set when lock drops while in RUN; cleared only by `reset`.

## Operation

- `pll_locked` passes through a two-flop synchroniser to give `lock_s`.
- States: WAIT_LOCK, COUNT, RUN.
  - WAIT_LOCK: if `lock_s` = 1, go to COUNT with `cnt` = 0.
  - COUNT, `lock_s` = 1: if `cnt` = LOCK_CYCLES−1, go to RUN; otherwise increment `cnt`.
  - COUNT, `lock_s` = 0: go to WAIT_LOCK and clear `cnt`.
  - RUN, `lock_s` = 0: go to WAIT_LOCK, clear `cnt`, set `lock_lost`.
- `sys_reset` is 1 in WAIT_LOCK and COUNT, 0 in RUN. It is updated on the same edge as the state register, not decoded combinationally.
- Divider counter `div_cnt`:
  - Held at 0 outside RUN.
  - In RUN, counts 0..DIV−1 and wraps to 0.
  - `cpu_en` is registered high for the cycle after the edge on which `div_cnt` = DIV−1.
  - DIV = 1: `cpu_en` is constantly 1 throughout RUN.
- Widths:
  - `cnt` is max(1, $clog2(LOCK_CYCLES)) bits.
  - `div_cnt` is max(1, $clog2(DIV)) bits.
  - No arithmetic may overflow at the terminal value; compare before incrementing.
- Reset values (while `reset` = 1):
  - State = WAIT_LOCK; both synchroniser flops = 0.
  - `cnt` = 0, `div_cnt` = 0.
  - `sys_reset` = 1, `cpu_en` = 0, `lock_lost` = 0.

## Timing

- Release latency:
  - Edge E1 is the first rising edge sampling `pll_locked` = 1, with lock held stable from then on.
  - `sys_reset` falls after edge E(LOCK_CYCLES+3): 2 edges for synchronisation, 1 edge for WAIT_LOCK→COUNT, LOCK_CYCLES edges of counting.
- First `cpu_en`:
  - Number the cycles after `sys_reset` falls as 1, 2, 3, …
  - `cpu_en` is high exactly in cycles n where n mod DIV = 0.
- Lock loss:
  - `pll_locked` sampled 0 at edge F gives `lock_s` = 0 after edge F+1.
  - `sys_reset` = 1 and `cpu_en` = 0 after edge F+2; `lock_lost` is also set on that edge if the block was in RUN.
- Lock glitches shorter than one `clk` period may be missed by the synchroniser. This is acceptable.
- A lock drop in COUNT restarts the full LOCK_CYCLES count; there is no partial credit.
- `reset` asserted mid-operation: all outputs take their reset values immediately, without waiting for `clk`.
- `reset` deasserted while lock is already high: the release sequence starts from the synchroniser. The E1 latency rule applies, with E1 = the first edge after `reset` falls.
- `reset` and a lock edge on the same cycle: `reset` wins.

## Structure

- Shared package `reset_ctrl_pkg`: state enum (WAIT_LOCK, COUNT, RUN) and the default constants for LOCK_CYCLES and DIV.
- One sub-module, `sync_bit`: two-flop synchroniser with asynchronous active-high reset to 0. Reusable for other asynchronous inputs (buttons, UART RX).
- FSM, counters and output registers live in `reset_ctrl`.

## Test plan

- LOCK_CYCLES = 4, DIV = 4, `pll_locked` rises before edge E1 and holds -> `sys_reset` = 1 through edge E6 and 0 after E7; `cpu_en` high in cycles 4, 8, 12 after release; `lock_lost` = 0.
- LOCK_CYCLES = 4, lock high for 3 edges after synchronisation, then low for 2, then high -> no release during the first burst; the release latency of 7 edges is measured from the second rising sample.
- In RUN, drop `pll_locked` at edge F -> `sys_reset` = 1 and `cpu_en` = 0 after F+2, `lock_lost` = 1; re-lock -> release after a further LOCK_CYCLES+3 edges, with `lock_lost` still 1.
- DIV = 1, LOCK_CYCLES = 1 -> `sys_reset` falls after edge E4; `cpu_en` = 1 on every cycle of RUN.
- Assert `reset` mid-RUN between clock edges -> `sys_reset` = 1, `cpu_en` = 0, `lock_lost` = 0 immediately; deassert with lock high -> release after LOCK_CYCLES+3 edges.
- LOCK_CYCLES = 1024, DIV = 3 -> release exactly after edge E1027; `cpu_en` period is exactly 3 with no drift over 1000 strobes.
